icache_refill_ctrl: RTL
=======================

Name: icache_refill_ctrl

Overview:
- Controller that sits directly upstream of the 64-line direct-mapped instruction cache line array (32-bit address = tag[31:11] | index[10:5] | word[4:2]).
- Accepts CPU fetch requests and runs a lookup on the array.
- On a miss, fetches the 256-bit line from memory as eight 32-bit beats, writes it into the array, then re-runs the lookup and returns the word.
- Drives the array's enable/compare/read/rst controls. The array acts on the falling edge; this block is rising-edge.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait per memory beat for mem_ack before the refill is aborted.
- LINE_WORDS, 8: words per line. Fixed at 8; any other value is illegal.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  fetch request; held until cpu_valid.
- cpu_addr  in  32  fetch byte address; bits [1:0] ignored.
- cpu_flush  in  1  invalidate-all request, sampled in IDLE only.
- cpu_valid  out  1  one-cycle pulse; cpu_data/cpu_err valid.
- cpu_data  out  32  fetched instruction word.
- cpu_err  out  1  refill timed out; cpu_data = 0.
- cpu_busy  out  1  high in every state except IDLE.
- cache_enable  out  1  array enable.
- cache_rst  out  1  array invalidate-all.
- cache_compare  out  1  array compare.
- cache_read  out  1  1 = read word, 0 = write line.
- cache_addr  out  32  array address.
- cache_line  out  256  refill line; word k is at [32k+31:32k].
- cache_hit  in  1  array tag match.
- cache_valid  in  1  array valid bit.
- cache_data  in  32  array read word, registered on the falling edge.
- mem_req  out  1  beat request; held until mem_ack.
- mem_addr  out  32  {line address[31:5], beat[2:0], 2'b00}.
- mem_ack  in  1  beat accepted; mem_rdata valid in the same cycle.
- mem_rdata  in  32  memory read data.

Behaviour:
- States: INIT, IDLE, LOOKUP, REFILL, WRITE, RESPOND, FLUSH.
- Async reset:
  - state goes to INIT.
  - All outputs 0: cpu_valid, cpu_err, mem_req, cache_* controls and cpu_data.
  - cpu_busy = 1.
  - beat = 0, timeout counter = 0, line buffer = 0.
- INIT: drive cache_enable = 1 and cache_rst = 1 for one cycle, then go to IDLE. Array valid bits are always cleared after reset.
- IDLE:
  - cpu_flush has priority over cpu_req and moves to FLUSH.
  - Otherwise cpu_req latches cpu_addr into req_addr and moves to LOOKUP.
- FLUSH: same drive as INIT, then back to IDLE.
- LOOKUP:
  - Drive cache_enable = 1, cache_compare = 1, cache_read = 1, cache_addr = req_addr.
  - Next rising edge: if cache_hit && cache_valid, go to RESPOND. Otherwise clear beat and the timeout counter, then go to REFILL.
- REFILL:
  - Drive mem_req = 1 and mem_addr per the port definition. cache controls are 0.
  - On mem_ack: buffer word[beat] = mem_rdata, beat increments, timeout counter clears. If beat == 7, go to WRITE.
  - Without mem_ack the timeout counter increments. On reaching TIMEOUT_CYCLES: drop mem_req, set an error flag, go to RESPOND. Nothing is written to the array.
- WRITE:
  - Drive cache_enable = 1, cache_read = 0, cache_compare = 0, cache_addr = req_addr, cache_line = buffer. The array writes tag/valid on the falling edge.
  - Go to LOOKUP. The second lookup must hit.
- RESPOND:
  - cpu_valid = 1 for exactly one cycle.
  - cpu_data = cache_data, or 0 on error. cpu_err = error flag.
  - Clear the flag and go to IDLE.
- Latency:
  - Hit: request accepted at edge t; cpu_valid is high in cycle t+2.
  - Miss with zero-wait memory: cpu_valid is high in cycle t+12 (LOOKUP, 8 REFILL, WRITE, LOOKUP, RESPOND).
- Constraints and corner cases:
  - mem_addr must not change while mem_req is high and mem_ack is low.
  - Reset mid-refill: mem_req drops immediately (async), the partial line is discarded, the array is never written, and INIT follows.
  - cpu_req deasserting mid-transaction is a protocol violation; the block completes the transaction regardless.
  - A hit on a different tag with valid = 0 is a miss.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_hits (32) and perf_misses (32).
  - perf_hits increments on each first-lookup hit; perf_misses on each first-lookup miss. The post-WRITE re-lookup is not counted.
  - Both saturate at 32'hFFFF_FFFF and clear on rst and on FLUSH.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then cpu_req with addr 0x0000_0804 → INIT pulses cache_rst; miss; mem_addr steps 0x800, 0x804, …, 0x81C; cpu_data = mem word at 0x804; cpu_valid at t+12.
- Repeat the same fetch with addr 0x0000_0808 → hit, no mem_req, cpu_valid at t+2, data = the word at 0x808.
- Fetch 0x0001_0804 (same index, different tag) → refill from 0x1_0800; a following fetch of 0x804 misses again.
- Memory stalls with mem_ack low for 255 cycles on beat 3 → cpu_valid with cpu_err = 1 and cpu_data = 0; a subsequent fetch of the same line misses.
- Assert rst during beat 5 of a refill → mem_req low immediately; after recovery the same address misses and refills cleanly.
- cpu_flush and cpu_req both high in IDLE → FLUSH first; the next fetch of a previously cached line misses. With ICACHE_PERF_CNT_EN defined, the counters read 0 after the flush.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Refill controller for a 64-line direct-mapped instruction cache.
// Address split: tag[31:11] | index[10:5] | word[4:2].
// Optional build macro ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
module icache_refill_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned LINE_WORDS     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0]               perf_hits,
  output logic [31:0]               perf_misses,
`endif
  input  logic                      cpu_req,
  input  logic [31:0]               cpu_addr,
  input  logic                      cpu_flush,
  output logic                      cpu_valid,
  output logic [31:0]               cpu_data,
  output logic                      cpu_err,
  output logic                      cpu_busy,
  output logic                      cache_enable,
  output logic                      cache_rst,
  output logic                      cache_compare,
  output logic                      cache_read,
  output logic [31:0]               cache_addr,
  output logic [32*LINE_WORDS-1:0]  cache_line,
  input  logic                      cache_hit,
  input  logic                      cache_valid,
  input  logic [31:0]               cache_data,
  output logic                      mem_req,
  output logic [31:0]               mem_addr,
  input  logic                      mem_ack,
  input  logic [31:0]               mem_rdata
);

  // LINE_WORDS is fixed at 8; the address split above depends on it.
  localparam int unsigned BEAT_W    = $clog2(LINE_WORDS);
  localparam int unsigned LINE_BITS = 32 * LINE_WORDS;
  localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_REFILL, S_WRITE, S_RESPOND, S_FLUSH
  } state_e;

  state_e               state_q, state_d;
  logic                 init_q, init_d;      // INIT pulse already issued
  logic                 relook_q, relook_d;  // current LOOKUP follows a WRITE
  logic                 err_q, err_d;
  logic [31:0]          req_addr_q, req_addr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [LINE_BITS-1:0] line_q, line_d;

  logic                 cpu_valid_q, cpu_valid_d;
  logic [31:0]          cpu_data_q, cpu_data_d;
  logic                 cpu_err_q, cpu_err_d;
  logic                 cpu_busy_q, cpu_busy_d;
  logic                 cache_enable_q, cache_enable_d;
  logic                 cache_rst_q, cache_rst_d;
  logic                 cache_compare_q, cache_compare_d;
  logic                 cache_read_q, cache_read_d;
  logic [31:0]          cache_addr_q, cache_addr_d;
  logic                 mem_req_q, mem_req_d;
  logic [31:0]          mem_addr_q, mem_addr_d;

  // Next-state logic plus output decode from the state being entered
  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    relook_d   = relook_q;
    err_d      = err_q;
    req_addr_d = req_addr_q;
    beat_d     = beat_q;
    to_d       = to_q;
    line_d     = line_q;

    unique case (state_q)
      S_INIT: begin
        if (!init_q) begin
          init_d = 1'b1;
        end else begin
          init_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (cpu_flush) begin
          state_d = S_FLUSH;
        end else if (cpu_req) begin
          req_addr_d = cpu_addr;
          state_d    = S_LOOKUP;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      S_LOOKUP: begin
        relook_d = 1'b0;
        if (cache_hit && cache_valid) begin
          state_d = S_RESPOND;
        end else begin
          beat_d  = '0;
          to_d    = '0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_ack) begin
          for (int unsigned k = 0; k < LINE_WORDS; k++) begin
            if (BEAT_W'(k) == beat_q) line_d[k*32 +: 32] = mem_rdata;
          end
          beat_d = beat_q + BEAT_W'(1);
          to_d   = '0;
          if (beat_q == LAST_BEAT) state_d = S_WRITE;
        end else begin
          to_d = to_q + TO_W'(1);
          if (to_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = S_RESPOND;
          end
        end
      end
      S_WRITE: begin
        relook_d = 1'b1;
        state_d  = S_LOOKUP;
      end
      S_RESPOND: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    cpu_busy_d      = (state_d != S_IDLE);
    cache_rst_d     = ((state_d == S_INIT) && init_d) || (state_d == S_FLUSH);
    cache_enable_d  = cache_rst_d || (state_d == S_LOOKUP) || (state_d == S_WRITE);
    cache_compare_d = (state_d == S_LOOKUP);
    cache_read_d    = (state_d == S_LOOKUP);
    cache_addr_d    = ((state_d == S_LOOKUP) || (state_d == S_WRITE)) ? req_addr_d : 32'd0;
    mem_req_d       = (state_d == S_REFILL);
    mem_addr_d      = (state_d == S_REFILL) ? {req_addr_d[31:5], beat_d, 2'b00} : 32'd0;
    cpu_valid_d     = (state_d == S_RESPOND);
    cpu_err_d       = (state_d == S_RESPOND) && err_d;
    cpu_data_d      = ((state_d == S_RESPOND) && !err_d) ? cache_data : 32'd0;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_INIT;
      init_q          <= 1'b0;
      relook_q        <= 1'b0;
      err_q           <= 1'b0;
      req_addr_q      <= '0;
      beat_q          <= '0;
      to_q            <= '0;
      line_q          <= '0;
      cpu_valid_q     <= 1'b0;
      cpu_data_q      <= '0;
      cpu_err_q       <= 1'b0;
      cpu_busy_q      <= 1'b1;
      cache_enable_q  <= 1'b0;
      cache_rst_q     <= 1'b0;
      cache_compare_q <= 1'b0;
      cache_read_q    <= 1'b0;
      cache_addr_q    <= '0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      init_q          <= init_d;
      relook_q        <= relook_d;
      err_q           <= err_d;
      req_addr_q      <= req_addr_d;
      beat_q          <= beat_d;
      to_q            <= to_d;
      line_q          <= line_d;
      cpu_valid_q     <= cpu_valid_d;
      cpu_data_q      <= cpu_data_d;
      cpu_err_q       <= cpu_err_d;
      cpu_busy_q      <= cpu_busy_d;
      cache_enable_q  <= cache_enable_d;
      cache_rst_q     <= cache_rst_d;
      cache_compare_q <= cache_compare_d;
      cache_read_q    <= cache_read_d;
      cache_addr_q    <= cache_addr_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
    end
  end

  assign cpu_valid     = cpu_valid_q;
  assign cpu_data      = cpu_data_q;
  assign cpu_err       = cpu_err_q;
  assign cpu_busy      = cpu_busy_q;
  assign cache_enable  = cache_enable_q;
  assign cache_rst     = cache_rst_q;
  assign cache_compare = cache_compare_q;
  assign cache_read    = cache_read_q;
  assign cache_addr    = cache_addr_q;
  assign cache_line    = line_q;
  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d;

  // First-lookup hit/miss counters; saturate, cleared on flush
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if ((state_q == S_IDLE) && cpu_flush) begin
      hits_d   = '0;
      misses_d = '0;
    end else if ((state_q == S_LOOKUP) && !relook_q) begin
      if (cache_hit && cache_valid) begin
        if (hits_q != 32'hFFFF_FFFF) hits_d = hits_q + 32'd1;
      end else begin
        if (misses_q != 32'hFFFF_FFFF) misses_d = misses_q + 32'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
`endif

endmodule
